// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - operation-side and memory-side bundles of the load/store sequencer
interface lsu_op_if;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] imm;
  logic [31:0] store_data;
  logic        done;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_cause;

  modport master (
    output lsu_valid, is_store, funct3, base, imm, store_data,
    input  lsu_ready, done, wb_valid, wb_data, err_valid, err_cause
  );
  modport slave (
    input  lsu_valid, is_store, funct3, base, imm, store_data,
    output lsu_ready, done, wb_valid, wb_data, err_valid, err_cause
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store sequencer with alignment checks and req/gnt/rvalid memory handshake
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  lsu_op_if.slave    op,
  lsu_mem_if.master  mem
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [2:0]  f3_q, f3_d;
  logic        st_q, st_d;
  logic [31:0] sd_q, sd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [1:0]  err_cause_q, err_cause_d;

  logic [31:0] ea_in;
  logic        illegal_in, misal_in, ready, req;
  logic [31:0] shifted, load_ext, lane_wdata;
  logic [3:0]  lane_be;

  assign ea_in = op.base + op.imm;
  assign ready = (state_q == S_IDLE) && !rst;
  assign req   = (state_q == S_REQ);

  always_comb begin
    illegal_in = 1'b0;
    if (op.is_store)
      illegal_in = op.funct3[2] || (op.funct3[1:0] == 2'b11);
    else
      illegal_in = (op.funct3 == 3'b011) || (op.funct3[2:1] == 2'b11);
    misal_in = ((op.funct3[1:0] == 2'b01) && ea_in[0]) ||
               ((op.funct3[1:0] == 2'b10) && (ea_in[1:0] != 2'b00));
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  always_comb begin
    shifted  = mem.mem_rdata >> {ea_q[1:0], 3'b000};
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    lane_wdata = sd_q;
    lane_be    = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        lane_wdata = {4{sd_q[7:0]}};
        lane_be    = 4'b0001 << ea_q[1:0];
      end
      2'b01: begin
        lane_wdata = {2{sd_q[15:0]}};
        lane_be    = ea_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = sd_q;
        lane_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ea_d        = ea_q;
    f3_d        = f3_q;
    st_d        = st_q;
    sd_d        = sd_q;
    cnt_d       = cnt_q;
    wb_data_d   = wb_data_q;
    err_cause_d = err_cause_q;
    case (state_q)
      S_IDLE: begin
        if (op.lsu_valid && ready) begin
          ea_d        = ea_in;
          f3_d        = op.funct3;
          st_d        = op.is_store;
          sd_d        = op.store_data;
          cnt_d       = 8'h00;
          wb_data_d   = 32'h0;
          err_cause_d = 2'b00;
          if (illegal_in) begin
            err_cause_d = 2'b11;
            state_d     = S_ERR;
          end else if (misal_in) begin
            err_cause_d = 2'b01;
            state_d     = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'h01;
        if (mem.mem_gnt) begin
          state_d = st_q ? S_DONE : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          err_cause_d = 2'b10;
          state_d     = S_ERR;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'h01;
        if (mem.mem_rvalid) begin
          wb_data_d = load_ext;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_cause_d = 2'b10;
          state_d     = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ea_q        <= 32'h0;
      f3_q        <= 3'b000;
      st_q        <= 1'b0;
      sd_q        <= 32'h0;
      cnt_q       <= 8'h00;
      wb_data_q   <= 32'h0;
      err_cause_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      ea_q        <= ea_d;
      f3_q        <= f3_d;
      st_q        <= st_d;
      sd_q        <= sd_d;
      cnt_q       <= cnt_d;
      wb_data_q   <= wb_data_d;
      err_cause_q <= err_cause_d;
    end
  end

  // Bus outputs are forced to zero outside REQ so nothing stale reaches memory.
  assign mem.mem_req   = req;
  assign mem.mem_we    = req && st_q;
  assign mem.mem_addr  = req ? {ea_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_wdata = (req && st_q) ? lane_wdata : 32'h0;
  assign mem.mem_be    = req ? (st_q ? lane_be : 4'b1111) : 4'b0000;

  assign op.lsu_ready = ready;
  assign op.done      = (state_q == S_DONE);
  assign op.wb_valid  = (state_q == S_DONE) && !st_q;
  assign op.wb_data   = wb_data_q;
  assign op.err_valid = (state_q == S_ERR);
  assign op.err_cause = err_cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lsu_op_if  op_if ();
  lsu_mem_if mem_if ();

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .op  (op_if.slave),
    .mem (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [2:0]  lv_f3    [6];
  logic [31:0] lv_base  [6];
  logic [31:0] lv_imm   [6];
  logic [31:0] lv_rdata [6];
  logic [31:0] lv_addr  [6];
  logic [31:0] lv_exp   [6];

  task automatic offer(input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] sd);
    op_if.lsu_valid  = 1'b1;
    op_if.is_store   = st;
    op_if.funct3     = f3;
    op_if.base       = b;
    op_if.imm        = im;
    op_if.store_data = sd;
    @(negedge clk);
    op_if.lsu_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (op_if.lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", op_if.lsu_ready); end
    checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_if.mem_req); end
    checks++; if ({op_if.done, op_if.wb_valid, op_if.err_valid} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {op_if.done, op_if.wb_valid, op_if.err_valid}); end
    checks++; if ({op_if.wb_data, op_if.err_cause} !== 34'h0) begin errors++; $display("FAIL reset_held: got %h expected 0", {op_if.wb_data, op_if.err_cause}); end
    checks++; if ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_be} !== 69'h0) begin errors++; $display("FAIL reset_bus: got %h expected 0", {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_be}); end
    rst = 1'b0;
    #1;
    checks++; if (op_if.lsu_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", op_if.lsu_ready); end
  endtask

  task automatic test_load_extend;
    lv_f3    = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b100, 3'b000};
    lv_base  = '{32'h1000, 32'h2000, 32'h2000, 32'h4000, 32'h5000, 32'h5000};
    lv_imm   = '{32'hFFFF_FFFF, 32'h2, 32'h2, 32'h0, 32'h1, 32'h1};
    lv_rdata = '{32'h8011_2233, 32'hBEEF_1234, 32'hBEEF_1234, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_F600};
    lv_addr  = '{32'hFFC, 32'h2000, 32'h2000, 32'h4000, 32'h5000, 32'h5000};
    lv_exp   = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'hDEAD_BEEF, 32'h0000_0056, 32'hFFFF_FFF6};
    for (int i = 0; i < 6; i++) begin
      offer(1'b0, lv_f3[i], lv_base[i], lv_imm[i], 32'h0);
      checks++; if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_be} !== 6'b101111) begin errors++; $display("FAIL load%0d_req: got %b expected 101111", i, {mem_if.mem_req, mem_if.mem_we, mem_if.mem_be}); end
      checks++; if (mem_if.mem_addr !== lv_addr[i]) begin errors++; $display("FAIL load%0d_addr: got %h expected %h", i, mem_if.mem_addr, lv_addr[i]); end
      checks++; if (op_if.lsu_ready !== 1'b0) begin errors++; $display("FAIL load%0d_busy: got %b expected 0", i, op_if.lsu_ready); end
      mem_if.mem_gnt = 1'b1;
      @(negedge clk);
      mem_if.mem_gnt    = 1'b0;
      checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL load%0d_req_drop: got %b expected 0", i, mem_if.mem_req); end
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = lv_rdata[i];
      @(negedge clk);
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 32'h0;
      checks++; if ({op_if.done, op_if.wb_valid, op_if.err_valid} !== 3'b110) begin errors++; $display("FAIL load%0d_pulse: got %b expected 110", i, {op_if.done, op_if.wb_valid, op_if.err_valid}); end
      checks++; if (op_if.wb_data !== lv_exp[i]) begin errors++; $display("FAIL load%0d_data: got %h expected %h", i, op_if.wb_data, lv_exp[i]); end
      @(negedge clk);
      checks++; if ({op_if.done, op_if.wb_valid, op_if.lsu_ready} !== 3'b001) begin errors++; $display("FAIL load%0d_after: got %b expected 001", i, {op_if.done, op_if.wb_valid, op_if.lsu_ready}); end
      checks++; if (op_if.wb_data !== lv_exp[i]) begin errors++; $display("FAIL load%0d_hold: got %h expected %h", i, op_if.wb_data, lv_exp[i]); end
    end
  endtask

  task automatic test_store_lanes;
    offer(1'b1, 3'b000, 32'h3000, 32'h3, 32'h0000_00A5);
    for (int c = 0; c < 3; c++) begin
      checks++; if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_be} !== 6'b111000) begin errors++; $display("FAIL sb_req_c%0d: got %b expected 111000", c, {mem_if.mem_req, mem_if.mem_we, mem_if.mem_be}); end
      checks++; if ({mem_if.mem_addr, mem_if.mem_wdata} !== {32'h3000, 32'hA5A5_A5A5}) begin errors++; $display("FAIL sb_bus_c%0d: got %h expected 00003000a5a5a5a5", c, {mem_if.mem_addr, mem_if.mem_wdata}); end
      @(negedge clk);
    end
    checks++; if (mem_if.mem_req !== 1'b1) begin errors++; $display("FAIL sb_req_c3: got %b expected 1", mem_if.mem_req); end
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    checks++; if ({op_if.done, op_if.wb_valid, op_if.err_valid} !== 3'b100) begin errors++; $display("FAIL sb_done: got %b expected 100", {op_if.done, op_if.wb_valid, op_if.err_valid}); end
    @(negedge clk);
    offer(1'b1, 3'b001, 32'h3000, 32'h2, 32'h1234_ABCD);
    checks++; if ({mem_if.mem_be, mem_if.mem_wdata} !== {4'b1100, 32'hABCD_ABCD}) begin errors++; $display("FAIL sh_lanes: got %h expected cabcdabcd", {mem_if.mem_be, mem_if.mem_wdata}); end
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    checks++; if (op_if.done !== 1'b1) begin errors++; $display("FAIL sh_done: got %b expected 1", op_if.done); end
    @(negedge clk);
    offer(1'b1, 3'b010, 32'h3000, 32'h4, 32'h1234_ABCD);
    checks++; if ({mem_if.mem_be, mem_if.mem_wdata, mem_if.mem_addr} !== {4'b1111, 32'h1234_ABCD, 32'h3004}) begin errors++; $display("FAIL sw_lanes: got %h expected f1234abcd00003004", {mem_if.mem_be, mem_if.mem_wdata, mem_if.mem_addr}); end
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    checks++; if (op_if.done !== 1'b1) begin errors++; $display("FAIL sw_done: got %b expected 1", op_if.done); end
    @(negedge clk);
  endtask

  task automatic test_errors;
    offer(1'b0, 3'b010, 32'h4000, 32'h2, 32'h0);
    checks++; if ({op_if.err_valid, op_if.err_cause, mem_if.mem_req, op_if.done} !== 5'b10100) begin errors++; $display("FAIL lw_misaligned: got %b expected 10100", {op_if.err_valid, op_if.err_cause, mem_if.mem_req, op_if.done}); end
    @(negedge clk);
    checks++; if ({op_if.err_valid, op_if.err_cause} !== 3'b001) begin errors++; $display("FAIL misaligned_hold: got %b expected 001", {op_if.err_valid, op_if.err_cause}); end
    offer(1'b1, 3'b011, 32'h4000, 32'h0, 32'h0);
    checks++; if ({op_if.err_valid, op_if.err_cause, mem_if.mem_req} !== 4'b1110) begin errors++; $display("FAIL sw_illegal: got %b expected 1110", {op_if.err_valid, op_if.err_cause, mem_if.mem_req}); end
    @(negedge clk);
    offer(1'b0, 3'b110, 32'h4000, 32'h1, 32'h0);
    checks++; if ({op_if.err_valid, op_if.err_cause} !== 3'b111) begin errors++; $display("FAIL illegal_priority: got %b expected 111", {op_if.err_valid, op_if.err_cause}); end
    @(negedge clk);
    offer(1'b0, 3'b001, 32'h4000, 32'h3, 32'h0);
    checks++; if ({op_if.err_valid, op_if.err_cause} !== 3'b101) begin errors++; $display("FAIL lh_misaligned: got %b expected 101", {op_if.err_valid, op_if.err_cause}); end
    @(negedge clk);
    offer(1'b0, 3'b100, 32'h4000, 32'h3, 32'h0);
    checks++; if ({mem_if.mem_req, op_if.err_cause} !== 3'b100) begin errors++; $display("FAIL lbu_clear_cause: got %b expected 100", {mem_if.mem_req, op_if.err_cause}); end
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'hC3_00_00_00;
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    checks++; if ({op_if.wb_valid, op_if.wb_data} !== {1'b1, 32'h0000_00C3}) begin errors++; $display("FAIL lbu_top_byte: got %h expected 1000000c3", {op_if.wb_valid, op_if.wb_data}); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    offer(1'b0, 3'b010, 32'h6000, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checks++; if ({mem_if.mem_req, op_if.err_valid} !== 2'b10) begin errors++; $display("FAIL to_req_c%0d: got %b expected 10", c, {mem_if.mem_req, op_if.err_valid}); end
      @(negedge clk);
    end
    checks++; if ({op_if.err_valid, op_if.err_cause, mem_if.mem_req, op_if.done} !== 5'b11000) begin errors++; $display("FAIL timeout_req: got %b expected 11000", {op_if.err_valid, op_if.err_cause, mem_if.mem_req, op_if.done}); end
    @(negedge clk);
    offer(1'b0, 3'b010, 32'h6000, 32'h0, 32'h0);
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({op_if.err_valid, op_if.err_cause, op_if.wb_valid} !== 4'b1100) begin errors++; $display("FAIL timeout_wait: got %b expected 1100", {op_if.err_valid, op_if.err_cause, op_if.wb_valid}); end
    @(negedge clk);
    offer(1'b0, 3'b010, 32'h6000, 32'h0, 32'h0);
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    checks++; if ({op_if.err_valid, op_if.done, op_if.wb_valid, op_if.wb_data} !== {3'b011, 32'h0BAD_F00D}) begin errors++; $display("FAIL rvalid_last_cycle: got %h expected 30badf00d", {op_if.err_valid, op_if.done, op_if.wb_valid, op_if.wb_data}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    offer(1'b0, 3'b010, 32'h7000, 32'h0, 32'h0);
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({op_if.lsu_ready, mem_if.mem_req} !== 2'b00) begin errors++; $display("FAIL mid_rst_during: got %b expected 00", {op_if.lsu_ready, mem_if.mem_req}); end
    rst = 1'b0;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'h1111_2222;
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    checks++; if ({op_if.done, op_if.wb_valid, op_if.err_valid, op_if.lsu_ready} !== 4'b0001) begin errors++; $display("FAIL mid_rst_stale: got %b expected 0001", {op_if.done, op_if.wb_valid, op_if.err_valid, op_if.lsu_ready}); end
    checks++; if (op_if.wb_data !== 32'h0) begin errors++; $display("FAIL mid_rst_wbdata: got %h expected 0", op_if.wb_data); end
    @(negedge clk);
    checks++; if ({op_if.done, op_if.wb_valid, op_if.lsu_ready} !== 3'b001) begin errors++; $display("FAIL mid_rst_idle: got %b expected 001", {op_if.done, op_if.wb_valid, op_if.lsu_ready}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    op_if.lsu_valid   = 1'b0;
    op_if.is_store    = 1'b0;
    op_if.funct3      = 3'b000;
    op_if.base        = 32'h0;
    op_if.imm         = 32'h0;
    op_if.store_data  = 32'h0;
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 32'h0;
    @(negedge clk);
    test_reset;
    @(negedge clk);
    test_load_extend;
    test_store_lanes;
    test_errors;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
